// File: rtl/serial_pkg.sv
// Shared constants for the one-wire synchronous serial link.
// The transmitter and the receiver both import this package.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      GUARD
   } state_t;

   localparam logic START_LEVEL = 1'b1;
   localparam logic IDLE_LEVEL  = 1'b0;
   localparam int   FRAME_WIDTH = 8;

endpackage

// File: rtl/serial_rx.sv
// serial_rx: deserializer for the one-wire synchronous serial link.
// Ports: Clk, Reset (sync, active-high), SDin (serial line),
//   Ack (consumer accept), PDout (word), Valid (word held),
//   Busy (frame in flight), FrameErr / Overrun (one-cycle pulses).
module serial_rx
   import serial_pkg::*;
#(
   parameter int WIDTH = FRAME_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             SDin,
   input  logic             Ack,
   output logic [WIDTH-1:0] PDout,
   output logic             Valid,
   output logic             Busy,
   output logic             FrameErr,
   output logic             Overrun
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] shreg;
   logic             good;
   logic             bad;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // A high guard bit ends the frame; it is never taken as a start bit.
   always_comb begin
      state_nx = state;
      good     = 1'b0;
      bad      = 1'b0;
      unique case (state)
         IDLE: begin
            if (SDin == START_LEVEL) begin
               state_nx = DATA;
            end
         end
         DATA: begin
            if (count == LAST) begin
               state_nx = GUARD;
            end
         end
         GUARD: begin
            state_nx = IDLE;
            if (SDin == IDLE_LEVEL) begin
               good = 1'b1;
            end else begin
               bad = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign Busy = (state != IDLE);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count    <= '0;
         shreg    <= '0;
         PDout    <= '0;
         Valid    <= 1'b0;
         FrameErr <= 1'b0;
         Overrun  <= 1'b0;
      end else begin
         FrameErr <= bad;
         Overrun  <= good & Valid & ~Ack;
         if (state == IDLE) begin
            count <= '0;
         end
         if (state == DATA) begin
            shreg <= {shreg[WIDTH-2:0], SDin};
            count <= count + 1'b1;
         end
         // A completing frame wins over Ack: the new word stays valid.
         if (good) begin
            PDout <= shreg;
            Valid <= 1'b1;
         end else if (Ack) begin
            Valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx with a scoreboard of expected words.
// Frames are produced by a small transmitter model in the bench.
module tb_serial_rx;

   localparam int W = 8;

   logic         Clk;
   logic         Reset;
   logic         SDin;
   logic         Ack;
   logic [W-1:0] PDout;
   logic         Valid;
   logic         Busy;
   logic         FrameErr;
   logic         Overrun;

   int checks = 0;
   int errors = 0;
   int busy_cycles;
   logic [W-1:0] sb[$];

   serial_rx #(.WIDTH(W)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .SDin     (SDin),
      .Ack      (Ack),
      .PDout    (PDout),
      .Valid    (Valid),
      .Busy     (Busy),
      .FrameErr (FrameErr),
      .Overrun  (Overrun)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
      if (Busy === 1'b1) busy_cycles++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one frame; the last tick is the guard edge.
   task automatic send_frame(input logic [W-1:0] d, input logic guard,
                             input logic ack_guard);
      logic [W-1:0] e;
      if (guard == 1'b0) sb.push_back(d);
      SDin = 1'b1;
      tick();
      for (int i = W - 1; i >= 0; i--) begin
         SDin = d[i];
         tick();
      end
      SDin = guard;
      Ack  = ack_guard;
      tick();
      SDin = 1'b0;
      Ack  = 1'b0;
      if (guard == 1'b0) begin
         if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("pdout", 32'(PDout), 32'(e));
            chk("valid", 32'(Valid), 32'd1);
         end
      end
   endtask

   initial begin
      logic [W-1:0] r;
      Reset = 1'b1;
      SDin  = 1'b0;
      Ack   = 1'b0;
      busy_cycles = 0;
      tick();
      tick();
      chk("rst_pdout", 32'(PDout), 32'd0);
      chk("rst_valid", 32'(Valid), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_ferr", 32'(FrameErr), 32'd0);
      chk("rst_ovr", 32'(Overrun), 32'd0);
      Reset = 1'b0;
      tick();

      send_frame(8'hA5, 1'b0, 1'b0);
      chk("a5_ferr", 32'(FrameErr), 32'd0);
      chk("a5_busy", 32'(Busy), 32'd0);
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
      chk("ack_valid", 32'(Valid), 32'd0);
      chk("ack_pdout", 32'(PDout), 32'hA5);
      tick();

      send_frame(8'h81, 1'b1, 1'b0);
      chk("fe_pulse", 32'(FrameErr), 32'd1);
      chk("fe_valid", 32'(Valid), 32'd0);
      chk("fe_pdout", 32'(PDout), 32'hA5);
      tick();
      chk("fe_clear", 32'(FrameErr), 32'd0);
      chk("fe_idle", 32'(Busy), 32'd0);
      tick();
      chk("fe_idle2", 32'(Busy), 32'd0);

      send_frame(8'h3C, 1'b0, 1'b0);
      chk("ov1_none", 32'(Overrun), 32'd0);
      send_frame(8'hFF, 1'b0, 1'b0);
      chk("ov2_pulse", 32'(Overrun), 32'd1);
      tick();
      chk("ov2_clear", 32'(Overrun), 32'd0);
      chk("ov2_valid", 32'(Valid), 32'd1);
      send_frame(8'h12, 1'b0, 1'b1);
      chk("ov3_none", 32'(Overrun), 32'd0);
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
      chk("ov3_ack", 32'(Valid), 32'd0);

      SDin = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         r = 8'h5A;
         SDin = r[W-1-i];
         tick();
      end
      Reset = 1'b1;
      SDin  = 1'b1;
      tick();
      Reset = 1'b0;
      SDin  = 1'b0;
      chk("mr_state", 32'(Busy), 32'd0);
      chk("mr_pdout", 32'(PDout), 32'd0);
      chk("mr_valid", 32'(Valid), 32'd0);
      send_frame(8'h0F, 1'b0, 1'b0);
      chk("mr_ferr", 32'(FrameErr), 32'd0);
      Ack = 1'b1;
      tick();
      Ack = 1'b0;
      tick();

      busy_cycles = 0;
      send_frame(8'h00, 1'b0, 1'b0);
      chk("z_busy", 32'(busy_cycles), 32'd9);
      Ack = 1'b1;
      tick();
      Ack = 1'b0;

      for (int n = 0; n < 16; n++) begin
         r = 8'($urandom_range(0, 255));
         send_frame(r, 1'b0, 1'b1);
         chk("rnd_ferr", 32'(FrameErr), 32'd0);
         chk("rnd_ovr", 32'(Overrun), 32'd0);
      end
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
